ifu_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the instruction memory. Owns the fetch PC, drives the IM

---
 rtl/ifu_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch sequencer; owns the fetch PC, feeds a DEPTH-entry
// {pc, instr} FIFO to decode (valid/ready), flushes on redirect, sticky fault.
// Ports: clk/reset (sync, active-high); im_pc/im_instr to IM;
//   redirect_valid/redirect_pc; out_valid/out_ready/out_instr/out_pc to decode;
//   fault/fault_pc report a misaligned or out-of-range fetch PC.
module ifu_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0]   IM_BYTES = 32'(IM_WORDS * 4);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);

  typedef enum logic {
    FETCH,
    FAULT
  } state_t;

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   pc_buf  [DEPTH];
  logic [31:0]   ins_buf [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] count_q;
  logic          fault_q;
  logic [31:0]   fault_pc_q;

  logic [31:0] off;
  logic        in_range;
  logic        pop;
  logic        space;
  logic        push;
  logic        detect;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // PCs below PC_RESET wrap to a huge offset and fail the bound.
  assign off      = pc_q - PC_RESET;
  assign in_range = (pc_q[1:0] == 2'b00) && (off < IM_BYTES);
  assign pop      = out_valid & out_ready;
  assign space    = (count_q < FULL) | pop;
  assign push     = (state_q == FETCH) & in_range & space
                  & ~redirect_valid;
  assign detect   = (state_q == FETCH) & ~in_range
                  & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= PC_RESET;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_buf[i]  <= '0;
        ins_buf[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush drops everything, including a same-cycle pop's successor.
      state_q <= FETCH;
      pc_q    <= redirect_pc;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (push) begin
        pc_buf[wr_q]  <= pc_q;
        ins_buf[wr_q] <= im_instr;
        wr_q          <= nxt(wr_q);
        pc_q          <= pc_q + 32'd4;
      end
      if (pop) begin
        rd_q <= nxt(rd_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (detect) begin
        fault_q    <= 1'b1;
        fault_pc_q <= pc_q;
        state_q    <= FAULT;
      end
    end
  end

  assign im_pc     = pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_buf[rd_q];
  assign out_instr = ins_buf[rd_q];
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: self-checking bench for ifu_fetch_ctrl.
// Scoreboard for streamed fetches, vector table for redirect/fault cases.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        ef;
    logic [31:0] efpc;
    logic [31:0] eim;
  } vec_t;

  vec_t tbl[17];

  ifu_fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .im_pc(im_pc),
    .im_instr(im_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .fault(fault),
    .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1000_0001 + ((pc - 32'h3000) >> 2);
  endfunction

  assign im_instr = instr_of(im_pc);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out();
    logic [31:0] e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %08h expected none", out_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, instr_of(e));
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      check_out();
      step();
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    step();
    step();
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_im_pc"}, im_pc, 32'h3000);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
    chk({tag, "_fault_pc"}, fault_pc, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h3042, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h3042};
    tbl[1]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1, 32'h3042, 32'h3042};
    tbl[2]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1, 32'h3042, 32'h3042};
    tbl[3]  = '{1'b1, 32'h3100, 1'b1, 1'b0, 32'h0,    1'b0, 32'h3042, 32'h3100};
    tbl[4]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h3100, 1'b0, 32'h3042, 32'h3104};
    tbl[5]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h3104, 1'b0, 32'h3042, 32'h3108};
    tbl[6]  = '{1'b1, 32'h6FFC, 1'b1, 1'b0, 32'h0,    1'b0, 32'h3042, 32'h6FFC};
    tbl[7]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h6FFC, 1'b0, 32'h3042, 32'h7000};
    tbl[8]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1, 32'h7000, 32'h7000};
    tbl[9]  = '{1'b1, 32'h2FFC, 1'b1, 1'b0, 32'h0,    1'b0, 32'h7000, 32'h2FFC};
    tbl[10] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1, 32'h2FFC, 32'h2FFC};
    tbl[11] = '{1'b1, 32'h6FF8, 1'b0, 1'b0, 32'h0,    1'b0, 32'h2FFC, 32'h6FF8};
    tbl[12] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h6FF8, 1'b0, 32'h2FFC, 32'h6FFC};
    tbl[13] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h6FF8, 1'b0, 32'h2FFC, 32'h7000};
    tbl[14] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h6FF8, 1'b1, 32'h7000, 32'h7000};
    tbl[15] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h6FFC, 1'b1, 32'h7000, 32'h7000};
    tbl[16] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1, 32'h7000, 32'h7000};

    // 1: reset state, then one instruction per cycle
    do_reset();
    chk_reset_state("t1_rst");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back(32'h3000 + 32'(4 * k));
    run(5);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2: backpressure fills the buffer, release drains in order
    do_reset();
    repeat (5) step();
    chk("t2_im_pc", im_pc, 32'h3008);
    chk("t2_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_head", out_pc, 32'h3000);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) sb_q.push_back(32'h3000 + 32'(4 * k));
    run(4);
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // 3: redirect with full buffer, head popped the same cycle
    do_reset();
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3040;
    out_ready      = 1'b1;
    sb_q.push_back(32'h3000);
    check_out();
    step();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("t3_im_pc", im_pc, 32'h3040);
    for (int k = 0; k < 3; k++) sb_q.push_back(32'h3040 + 32'(4 * k));
    run(4);
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4/5: misaligned, upper/lower bound faults, drain during fault
    do_reset();
    for (int i = 0; i < 17; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid},
          {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d_fault", i), {31'b0, fault},
          {31'b0, tbl[i].ef});
      chk($sformatf("vec%0d_fault_pc", i), fault_pc, tbl[i].efpc);
      chk($sformatf("vec%0d_im_pc", i), im_pc, tbl[i].eim);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("vec%0d_out_instr", i), out_instr,
            instr_of(tbl[i].epc));
      end
    end
    redirect_valid = 1'b0;

    // 6: reset beats a concurrent redirect with full buffer and fault
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6FF8;
    out_ready      = 1'b0;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    chk("t6_pre_fault", {31'b0, fault}, 32'd1);
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3100;
    out_ready      = 1'b1;
    step();
    chk_reset_state("t6_rst");
    reset          = 1'b0;
    redirect_valid = 1'b0;

    // random backpressure: strictly sequential delivery
    do_reset();
    for (int k = 0; k < 64; k++) sb_q.push_back(32'h3000 + 32'(4 * k));
    for (int c = 0; c < 60; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      check_out();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
